// File: rtl/lock_key_pkg.sv
// rtl/lock_key_pkg.sv - shared types and constants for the lock key loader
//
// Purpose: FSM state encoding, default key width, fail counter width and a
// saturating increment helper shared by the loader and its serial assembler.
// Optional macro LOCK_KEY_LOCKOUT_EN adds the LOCKOUT state to the encoding.

package lock_key_pkg;

  localparam int KEY_W_DEFAULT = 16;
  localparam int FAIL_W        = 2;

`ifdef LOCK_KEY_LOCKOUT_EN
  typedef enum logic [2:0] {
    RECV,
    SETTLE,
    CHECK,
    DONE,
    LOCKOUT
  } state_t;
`else
  typedef enum logic [1:0] {
    RECV,
    SETTLE,
    CHECK,
    DONE
  } state_t;
`endif

  // Saturates at all-ones so the count never wraps back to zero.
  function automatic logic [FAIL_W-1:0] fail_inc(input logic [FAIL_W-1:0] cnt);
    return (cnt == {FAIL_W{1'b1}}) ? cnt : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/lock_key_shift_rx.sv
// rtl/lock_key_shift_rx.sv - serial LSB-first key assembler
//
// Purpose: accepts one key bit per valid/ready handshake into a shadow
// register and flags the cycle in which the final bit is accepted.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   en          reception enabled (loader in RECV); drives key_ready
//   clear       discard shadow contents and restart at bit 0
//   key_bit     serial key bit, LSB first
//   key_valid   key_bit valid this cycle
//   key_ready   bit accepted this cycle when key_valid is high
//   key_word    shadow with the current bit merged at bit_cnt
//   done        final bit accepted this cycle; key_word is the full key

module lock_key_shift_rx
  import lock_key_pkg::*;
#(
  parameter int KEY_W = KEY_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic             key_bit,
  input  logic             key_valid,
  output logic             key_ready,
  output logic [KEY_W-1:0] key_word,
  output logic             done
);

  localparam int CNT_W = (KEY_W > 1) ? $clog2(KEY_W) : 1;

  logic [KEY_W-1:0] shadow;
  logic [CNT_W-1:0] bit_cnt;
  logic             accept;

  assign key_ready = en;
  assign accept    = key_valid & en;
  assign done      = accept && (bit_cnt == CNT_W'(KEY_W - 1));

  // Merging the in-flight bit lets the loader capture the whole key in the
  // same edge that accepts the last bit.
  always_comb begin
    key_word          = shadow;
    key_word[bit_cnt] = key_bit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow  <= '0;
      bit_cnt <= '0;
    end else if (clear) begin
      shadow  <= '0;
      bit_cnt <= '0;
    end else if (accept) begin
      shadow[bit_cnt] <= key_bit;
      bit_cnt         <= done ? '0 : bit_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/lock_key_loader.sv
// rtl/lock_key_loader.sv - key provisioning FSM for a logic-locked core
//
// Purpose: assembles a serial key, drives it onto the locked core, pulses
// check_start after a settle delay and latches or clears the key according
// to the external checker's verdict.
// Optional macro LOCK_KEY_LOCKOUT_EN: after MAX_FAIL failures the loader
// enters LOCKOUT and stays there until reset.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   key_bit      serial key bit, LSB first
//   key_valid    key_bit valid this cycle
//   key_ready    loader accepts a bit this cycle
//   key_out      key to the locked core; key_out[0] feeds keyinput1
//   check_start  one-cycle pulse to start the checker
//   check_done   checker verdict valid this cycle
//   check_pass   verdict: 1 = outputs matched
//   unlocked     key verified and latched
//   busy         high while settling or checking
//   fail_cnt     saturating count of failed attempts

module lock_key_loader
  import lock_key_pkg::*;
#(
  parameter int KEY_W      = KEY_W_DEFAULT,
  parameter int SETTLE_CYC = 4
`ifdef LOCK_KEY_LOCKOUT_EN
  ,
  parameter int MAX_FAIL   = 3
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_bit,
  input  logic              key_valid,
  output logic              key_ready,
  output logic [KEY_W-1:0]  key_out,
  output logic              check_start,
  input  logic              check_done,
  input  logic              check_pass,
  output logic              unlocked,
  output logic              busy,
  output logic [FAIL_W-1:0] fail_cnt
);

  localparam int SC_W = $clog2(SETTLE_CYC + 1);

  state_t           state_q;
  state_t           state_d;
  logic [SC_W-1:0]  settle_cnt;
  logic             fail_evt;
  logic             rx_done;
  logic [KEY_W-1:0] rx_word;

  lock_key_shift_rx #(
    .KEY_W (KEY_W)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .en        (state_q == RECV),
    .clear     (fail_evt),
    .key_bit   (key_bit),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_word  (rx_word),
    .done      (rx_done)
  );

  assign unlocked = (state_q == DONE);

  // settle_cnt counts the full cycles the key has been on the core; the
  // pulse goes out in the cycle after SETTLE_CYC of them, still in SETTLE,
  // so a check_done coinciding with check_start is never sampled.
  always_comb begin
    state_d     = state_q;
    check_start = 1'b0;
    busy        = 1'b0;
    fail_evt    = 1'b0;
    case (state_q)
      RECV: begin
        if (rx_done) state_d = SETTLE;
      end
      SETTLE: begin
        busy = 1'b1;
        if (settle_cnt == SC_W'(SETTLE_CYC)) begin
          check_start = 1'b1;
          state_d     = CHECK;
        end
      end
      CHECK: begin
        busy = 1'b1;
        if (check_done) begin
          if (check_pass) begin
            state_d = DONE;
          end else begin
            fail_evt = 1'b1;
            state_d  = RECV;
`ifdef LOCK_KEY_LOCKOUT_EN
            if (fail_inc(fail_cnt) == FAIL_W'(MAX_FAIL)) state_d = LOCKOUT;
`endif
          end
        end
      end
      DONE: begin
        state_d = DONE;
      end
`ifdef LOCK_KEY_LOCKOUT_EN
      LOCKOUT: begin
        state_d = LOCKOUT;
      end
`endif
      default: begin
        state_d = RECV;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RECV;
      settle_cnt <= '0;
      key_out    <= '0;
      fail_cnt   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == SETTLE) settle_cnt <= settle_cnt + 1'b1;
      else                   settle_cnt <= '0;
      if (rx_done) key_out <= rx_word;
      if (fail_evt) begin
        key_out  <= '0;
        fail_cnt <= fail_inc(fail_cnt);
      end
    end
  end

endmodule

// File: tb/tb_lock_key_loader.sv
// tb/tb_lock_key_loader.sv - directed self-checking bench for lock_key_loader

module tb_lock_key_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_bit;
  logic        key_valid;
  logic        key_ready;
  logic [15:0] key_out;
  logic        check_start;
  logic        check_done;
  logic        check_pass;
  logic        unlocked;
  logic        busy;
  logic [1:0]  fail_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int n;
  logic flag;

  lock_key_loader dut (
    .clk         (clk),
    .rst         (rst),
    .key_bit     (key_bit),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .key_out     (key_out),
    .check_start (check_start),
    .check_done  (check_done),
    .check_pass  (check_pass),
    .unlocked    (unlocked),
    .busy        (busy),
    .fail_cnt    (fail_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic send_key(input logic [15:0] k);
    for (int i = 0; i < 16; i++) begin
      key_bit   = k[i];
      key_valid = 1'b1;
      tick();
    end
    key_valid = 1'b0;
    key_bit   = 1'b0;
  endtask

  // Cycles from the first key_out cycle until check_start; -1 on timeout.
  task automatic wait_start(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (check_start) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic result(input logic pass);
    check_done = 1'b1;
    check_pass = pass;
    tick();
    check_done = 1'b0;
    check_pass = 1'b0;
  endtask

  task automatic fail_attempt(input logic [15:0] k);
    send_key(k);
    wait_start(n);
    tick();
    result(1'b0);
  endtask

  initial begin
    rst        = 1'b1;
    key_bit    = 1'b0;
    key_valid  = 1'b0;
    check_done = 1'b0;
    check_pass = 1'b0;
    #1;
    check_val("rst_key_out", key_out, 0);
    check_val("rst_key_ready", key_ready, 1);
    check_val("rst_check_start", check_start, 0);
    check_val("rst_unlocked", unlocked, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_fail_cnt", fail_cnt, 0);
    tick();
    rst = 1'b0;
    tick();

    // Spurious verdict while receiving.
    result(1'b1);
    check_val("spur_unlocked", unlocked, 0);
    check_val("spur_key_ready", key_ready, 1);
    check_val("spur_busy", busy, 0);

    // Happy path, with a verdict coinciding with check_start ignored.
    send_key(16'hBA4C);
    check_val("happy_key_out", key_out, 16'hBA4C);
    check_val("happy_busy", busy, 1);
    check_val("happy_start_early", check_start, 0);
    wait_start(n);
    check_val("happy_start_lat", n, 4);
    result(1'b0);
    check_val("same_cycle_done_fail_cnt", fail_cnt, 0);
    check_val("same_cycle_done_key", key_out, 16'hBA4C);
    check_val("same_cycle_done_busy", busy, 1);
    result(1'b1);
    check_val("happy_unlocked", unlocked, 1);
    check_val("happy_key_ready", key_ready, 0);
    check_val("happy_busy_done", busy, 0);
    send_key(16'hFFFF);
    check_val("done_key_held", key_out, 16'hBA4C);
    check_val("done_unlocked_held", unlocked, 1);

    // Gapped stream: no partial key may be visible.
    do_reset();
    flag = 1'b0;
    for (int i = 0; i < 32; i++) begin
      key_valid = i[0];
      key_bit   = i[0] ? ((i >> 1) == 0) : 1'b1;
      tick();
      if (i < 31 && key_out !== 16'h0000) flag = 1'b1;
    end
    key_valid = 1'b0;
    key_bit   = 1'b0;
    check_val("gap_partial_seen", flag, 0);
    check_val("gap_key_out", key_out, 16'h0001);
    wait_start(n);
    check_val("gap_start_lat", n, 4);

    // Fail then retry.
    do_reset();
    fail_attempt(16'hFFFF);
    check_val("fail_key_out", key_out, 0);
    check_val("fail_cnt_1", fail_cnt, 1);
    check_val("fail_key_ready", key_ready, 1);
    check_val("fail_busy", busy, 0);
    send_key(16'hBA4C);
    check_val("retry_key_out", key_out, 16'hBA4C);
    wait_start(n);
    tick();
    result(1'b1);
    check_val("retry_unlocked", unlocked, 1);
    check_val("retry_fail_cnt", fail_cnt, 1);

    // Asynchronous reset during SETTLE.
    do_reset();
    fail_attempt(16'hFFFF);
    check_val("pre_rst_fail_cnt", fail_cnt, 1);
    send_key(16'hBA4C);
    tick();
    #2;
    rst = 1'b1;
    #1;
    check_val("arst_key_out", key_out, 0);
    check_val("arst_busy", busy, 0);
    check_val("arst_fail_cnt", fail_cnt, 0);
    check_val("arst_key_ready", key_ready, 1);
    flag = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i == 3) rst = 1'b0;
      tick();
      if (check_start) flag = 1'b1;
    end
    check_val("arst_no_start", flag, 0);

    // Three failures: saturation and lockout behaviour.
    do_reset();
    for (int i = 0; i < 3; i++) fail_attempt(16'hFFFF);
    check_val("three_fail_cnt", fail_cnt, 3);
`ifdef LOCK_KEY_LOCKOUT_EN
    check_val("lockout_key_ready", key_ready, 0);
    send_key(16'hBA4C);
    check_val("lockout_key_out", key_out, 0);
    check_val("lockout_busy", busy, 0);
    check_val("lockout_unlocked", unlocked, 0);
`else
    check_val("retry4_key_ready", key_ready, 1);
    send_key(16'hFFFF);
    check_val("retry4_key_out", key_out, 16'hFFFF);
    wait_start(n);
    check_val("retry4_start_lat", n, 4);
    tick();
    result(1'b0);
    check_val("retry4_fail_cnt_sat", fail_cnt, 3);
    check_val("retry4_key_ready_after", key_ready, 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
